sig_stabilizer: RTL and testbench

SIG_STABILIZER -- requirements
Module: sig_stabilizer

---
 rtl/sig_stab_pkg.sv | 30 +++
 rtl/sig_sync.sv | 31 +++
 rtl/sig_stabilizer.sv | 134 +++++++++++++
 tb/tb_sig_stabilizer.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/sig_stab_pkg.sv
// ============================================================================
// Module   : sig_stab_pkg
// Purpose  : Shared FSM state type and parameter limits for sig_stabilizer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package sig_stab_pkg;

    typedef enum logic [1:0] {
        IDLE_LO = 2'd0,
        CHK_HI  = 2'd1,
        IDLE_HI = 2'd2,
        CHK_LO  = 2'd3
    } sig_stab_state_t;

    localparam int c_SYNC_STAGES_MIN   = 2;
    localparam int c_SYNC_STAGES_MAX   = 4;
    localparam int c_STABLE_CYCLES_MIN = 1;

    // Out-of-range depths are pulled into the legal window.
    function automatic int clamp_sync(input int n);
        if (n < c_SYNC_STAGES_MIN) return c_SYNC_STAGES_MIN;
        if (n > c_SYNC_STAGES_MAX) return c_SYNC_STAGES_MAX;
        return n;
    endfunction

endpackage

`default_nettype wire

// File: rtl/sig_sync.sv
// ============================================================================
// Module   : sig_sync
// Purpose  : Multi-flop synchronizer for a single asynchronous bit.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sig_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] r_chain;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_chain <= '0;
        end else begin
            r_chain <= {r_chain[STAGES-2:0], d};
        end
    end

    assign q = r_chain[STAGES-1];

endmodule

`default_nettype wire

// File: rtl/sig_stabilizer.sv
// ============================================================================
// Module   : sig_stabilizer
// Purpose  : Synchronizes and debounces a raw input, flags edges, counts glitches.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sig_stabilizer
    import sig_stab_pkg::*;
#(
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = 4,
    parameter int CNT_W         = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sig_in,
    input  logic             glitch_clr,
    output logic             sig_out,
    output logic             rise,
    output logic             fall,
    output logic             changing,
    output logic [CNT_W-1:0] glitch_cnt
);

    localparam int c_STAGES   = clamp_sync(SYNC_STAGES);
    localparam int c_STABLE   = (STABLE_CYCLES < c_STABLE_CYCLES_MIN) ? c_STABLE_CYCLES_MIN : STABLE_CYCLES;
    localparam int c_CNT_BITS = $clog2(c_STABLE + 1);
    localparam logic [c_CNT_BITS-1:0] c_LAST       = c_CNT_BITS'(c_STABLE - 1);
    localparam logic [c_CNT_BITS-1:0] c_ONE        = c_CNT_BITS'(1);
    localparam logic [CNT_W-1:0]      c_GLITCH_MAX = {CNT_W{1'b1}};

    logic w_s;

    sig_sync #(
        .STAGES (c_STAGES)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (sig_in),
        .q   (w_s)
    );

    sig_stab_state_t         r_state, w_state_nxt;
    logic [c_CNT_BITS-1:0]   r_cnt, w_cnt_nxt;
    logic                    r_sig_out, w_out_nxt;
    logic                    r_rise, r_fall, r_changing;
    logic                    w_rise_nxt, w_fall_nxt;
    logic                    w_flip, w_glitch, w_differs;
    logic [CNT_W-1:0]        r_glitch_cnt;

    assign w_differs = (w_s != r_sig_out);

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_out_nxt   = r_sig_out;
        w_rise_nxt  = 1'b0;
        w_fall_nxt  = 1'b0;
        w_flip      = 1'b0;
        w_glitch    = 1'b0;

        case (r_state)
            IDLE_LO, IDLE_HI: begin
                if (w_differs) begin
                    if (c_STABLE == 1) begin
                        w_flip = 1'b1;
                    end else begin
                        w_state_nxt = (r_state == IDLE_LO) ? CHK_HI : CHK_LO;
                        w_cnt_nxt   = c_ONE;
                    end
                end
            end
            CHK_HI, CHK_LO: begin
                if (!w_differs) begin
                    w_state_nxt = (r_state == CHK_HI) ? IDLE_LO : IDLE_HI;
                    w_cnt_nxt   = '0;
                    w_glitch    = 1'b1;
                end else if (r_cnt == c_LAST) begin
                    w_flip = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + c_ONE;
                end
            end
            default: begin
                w_state_nxt = IDLE_LO;
                w_cnt_nxt   = '0;
            end
        endcase

        // A qualified change always lands in the idle state of the new level.
        if (w_flip) begin
            w_out_nxt   = w_s;
            w_rise_nxt  = w_s;
            w_fall_nxt  = ~w_s;
            w_state_nxt = w_s ? IDLE_HI : IDLE_LO;
            w_cnt_nxt   = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= IDLE_LO;
            r_cnt        <= '0;
            r_sig_out    <= 1'b0;
            r_rise       <= 1'b0;
            r_fall       <= 1'b0;
            r_changing   <= 1'b0;
            r_glitch_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_sig_out  <= w_out_nxt;
            r_rise     <= w_rise_nxt;
            r_fall     <= w_fall_nxt;
            r_changing <= w_rise_nxt | w_fall_nxt;
            // Clear takes priority over a coincident glitch.
            if (glitch_clr) begin
                r_glitch_cnt <= '0;
            end else if (w_glitch && (r_glitch_cnt != c_GLITCH_MAX)) begin
                r_glitch_cnt <= r_glitch_cnt + 1'b1;
            end
        end
    end

    assign sig_out    = r_sig_out;
    assign rise       = r_rise;
    assign fall       = r_fall;
    assign changing   = r_changing;
    assign glitch_cnt = r_glitch_cnt;

endmodule

`default_nettype wire

// File: tb/tb_sig_stabilizer.sv
// ============================================================================
// Module   : tb_sig_stabilizer
// Purpose  : Self-checking bench for sig_stabilizer against a sample-window model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sig_stabilizer;

    localparam int SYNC = 2;
    localparam int STAB = 4;
    localparam int CW   = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          sig_in;
    logic          glitch_clr;
    logic          sig_out, rise, fall, changing;
    logic [CW-1:0] glitch_cnt;

    sig_stabilizer #(
        .SYNC_STAGES   (SYNC),
        .STABLE_CYCLES (STAB),
        .CNT_W         (CW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .sig_in     (sig_in),
        .glitch_clr (glitch_clr),
        .sig_out    (sig_out),
        .rise       (rise),
        .fall       (fall),
        .changing   (changing),
        .glitch_cnt (glitch_cnt)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: the core sees sig_in delayed by SYNC edges; output flips once
    // the last STAB samples all disagree with it; a shorter disagreeing run
    // that ends is one glitch.
    bit m_in_q[$];
    bit m_hist[$];
    bit m_out, m_rise, m_fall;
    int m_glitch;
    bit last_out, last_chg;

    function automatic int trail();
        int n = 0;
        for (int i = m_hist.size() - 1; i >= 0; i--) begin
            if (m_hist[i] == m_out) break;
            n++;
        end
        return n;
    endfunction

    task automatic model_reset();
        m_in_q = {};
        for (int i = 0; i < SYNC; i++) m_in_q.push_back(1'b0);
        m_hist   = {};
        m_out    = 1'b0;
        m_rise   = 1'b0;
        m_fall   = 1'b0;
        m_glitch = 0;
        last_out = 1'b0;
        last_chg = 1'b0;
    endtask

    task automatic model_edge(input bit in, input bit clr);
        bit smp;
        int prev, run;
        smp = m_in_q.pop_front();
        m_in_q.push_back(in);
        prev = trail();
        m_hist.push_back(smp);
        if (m_hist.size() > STAB) void'(m_hist.pop_front());
        run = trail();
        m_rise = 1'b0;
        m_fall = 1'b0;
        if (run >= STAB) begin
            m_out  = ~m_out;
            m_rise = m_out;
            m_fall = ~m_out;
        end else if (smp == m_out && prev > 0 && m_glitch < (1 << CW) - 1) begin
            m_glitch++;
        end
        if (clr) m_glitch = 0;
    endtask

    task automatic compare_all();
        bit chg;
        chk("sig_out", sig_out, m_out);
        chk("rise", rise, m_rise);
        chk("fall", fall, m_fall);
        chk("changing", changing, m_rise | m_fall);
        chk("glitch_cnt", glitch_cnt, m_glitch);
        chk("changing_eq_or", changing, rise | fall);
        chk("rise_fall_excl", rise & fall, 1'b0);
        chg = (sig_out != last_out);
        chk("no_back_to_back", chg & last_chg, 1'b0);
        last_chg = chg;
        last_out = sig_out;
    endtask

    task automatic step(input bit in, input bit clr);
        sig_in     = in;
        glitch_clr = clr;
        @(posedge clk);
        model_edge(in, clr);
        #1;
        compare_all();
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_sig_out"}, sig_out, 1'b0);
        chk({tag, "_pulses"}, {rise, fall, changing}, 3'b000);
        chk({tag, "_glitch"}, glitch_cnt, '0);
    endtask

    // Asserted and released between clock edges, so clearing must be asynchronous.
    task automatic async_reset();
        #2 rst = 1'b0;
        #1 check_zero("async_rst");
        model_reset();
        #1 rst = 1'b1;
    endtask

    task automatic glitch3(input int clr_at);
        for (int k = 0; k < 6; k++) step(k < 3, k == clr_at);
    endtask

    initial begin
        int  edge_at, pulses;
        bit  lvl;
        int  len;

        rst        = 1'b0;
        sig_in     = 1'b0;
        glitch_clr = 1'b0;
        model_reset();

        for (int i = 0; i < 8; i++) begin
            @(negedge clk) sig_in = ~sig_in;
            @(posedge clk);
            #1 check_zero("in_reset");
        end

        sig_in = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
        for (int i = 0; i < 8; i++) step(1'b0, 1'b0);

        edge_at = 0; pulses = 0;
        for (int i = 1; i <= 12; i++) begin
            step(1'b1, 1'b0);
            if (sig_out && edge_at == 0) edge_at = i;
            if (rise) pulses++;
        end
        chk("rise_latency", edge_at, 6);
        chk("rise_width", pulses, 1);
        chk("rise_glitch_cnt", glitch_cnt, 0);

        edge_at = 0; pulses = 0;
        for (int i = 1; i <= 12; i++) begin
            step(1'b0, 1'b0);
            if (!sig_out && edge_at == 0) edge_at = i;
            if (fall) pulses++;
        end
        chk("fall_latency", edge_at, 6);
        chk("fall_width", pulses, 1);

        glitch3(-1);
        chk("glitch_out", sig_out, 1'b0);
        chk("glitch_one", glitch_cnt, 1);

        for (int g = 0; g < 259; g++) glitch3(-1);
        chk("glitch_sat", glitch_cnt, 255);

        glitch3(5);
        chk("clr_at_sat", glitch_cnt, 0);
        glitch3(5);
        chk("clr_beats_inc", glitch_cnt, 0);
        glitch3(-1);
        chk("count_after_clr", glitch_cnt, 1);

        // Abort a rising check partway, then expect a fresh full-latency rise.
        for (int i = 0; i < 8; i++) step(1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0);
        async_reset();
        edge_at = 0; pulses = 0;
        for (int i = 1; i <= 10; i++) begin
            step(1'b1, 1'b0);
            if (sig_out && edge_at == 0) edge_at = i;
            if (rise) pulses++;
        end
        chk("rst_mid_rise_latency", edge_at, 6);
        chk("rst_mid_rise_width", pulses, 1);

        chk("high_before_rst", sig_out, 1'b1);
        async_reset();

        for (int seg = 0; seg < 500; seg++) begin
            lvl = 1'($urandom_range(0, 1));
            len = $urandom_range(1, 9);
            for (int k = 0; k < len; k++) step(lvl, $urandom_range(0, 31) == 0);
            if ($urandom_range(0, 49) == 0) async_reset();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
